// File: rtl/imem_access_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory access arbiter.
// The optional fetch alignment check is enabled by defining IMEM_ALIGN_CHECK_EN.
package imem_access_arbiter_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    localparam int          DEPTH_DEF        = 512;
    localparam int          STARVE_LIMIT_DEF = 4;
    localparam logic [31:0] NOP              = 32'h0;

endpackage

// File: rtl/imem_access_arbiter_if.sv
// Fetch, loader and single-port memory signals shared between the arbiter and its neighbours.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface imem_access_arbiter_if
    import imem_access_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic          BootDone;
    logic          FetchReq;
    logic [31:0]   FetchAddr;
    logic          FetchValid;
    logic [31:0]   FetchInstr;
    logic          FetchStall;
    logic          LoadReq;
    logic [31:0]   LoadAddr;
    logic [31:0]   LoadData;
    logic          LoadAck;
    logic [AW-1:0] MemAddr;
    logic          MemWrEn;
    logic [31:0]   MemWrData;
    logic [31:0]   MemRdData;
    logic          AlignErr;

    modport slave (
        input  BootDone, FetchReq, FetchAddr, LoadReq, LoadAddr, LoadData, MemRdData,
        output FetchValid, FetchInstr, FetchStall, LoadAck, MemAddr, MemWrEn, MemWrData, AlignErr
    );

    modport master (
        output BootDone, FetchReq, FetchAddr, LoadReq, LoadAddr, LoadData, MemRdData,
        input  FetchValid, FetchInstr, FetchStall, LoadAck, MemAddr, MemWrEn, MemWrData, AlignErr
    );

endinterface

// File: rtl/imem_grant_ctl.sv
// BOOT/RUN state machine and starvation counter deciding which requester owns the memory port.
// Grants are suppressed combinationally while rst_i is high.
module imem_grant_ctl
    import imem_access_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic boot_done_i,
    input  logic fetch_req_i,
    input  logic load_req_i,
    output logic load_grant_o,
    output logic fetch_grant_o
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          force_fetch;

    // NOTE: state registers take <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= BOOT;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can leave one unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        load_grant_o  = 1'b0;
        fetch_grant_o = 1'b0;
        force_fetch   = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                BOOT: begin
                    load_grant_o = load_req_i;
                    starve_d     = '0;
                    if (boot_done_i) state_d = RUN;
                end
                RUN: begin
                    force_fetch   = fetch_req_i && (starve_q == LIMIT);
                    load_grant_o  = load_req_i && !force_fetch;
                    fetch_grant_o = fetch_req_i && !load_grant_o;
                    // Counts only loader wins over a waiting fetch; any gap in FetchReq forgives the debt.
                    if (fetch_grant_o || !fetch_req_i) starve_d = '0;
                    else if (starve_q != LIMIT)        starve_d = starve_q + 1'b1;
                end
                default: state_d = BOOT;
            endcase
        end
    end

endmodule

// File: rtl/imem_access_arbiter.sv
// Arbitrates a single-port synchronous-read instruction memory between fetch and program loader.
// Define IMEM_ALIGN_CHECK_EN to flag misaligned fetches (sticky AlignErr, NOP returned).
module imem_access_arbiter
    import imem_access_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    imem_access_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic          load_grant, fetch_grant;
    logic [AW-1:0] load_idx, fetch_idx;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          fetch_valid_q;

    imem_grant_ctl #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_ctl (
        .clk_i         (Clk),
        .rst_i         (Rst),
        .boot_done_i   (bus.BootDone),
        .fetch_req_i   (bus.FetchReq),
        .load_req_i    (bus.LoadReq),
        .load_grant_o  (load_grant),
        .fetch_grant_o (fetch_grant)
    );

    assign load_idx  = bus.LoadAddr[AW+1:2];
    assign fetch_idx = bus.FetchAddr[AW+1:2];

    // The memory address lingers on the last granted index when the port is idle.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (Rst)              mem_addr_d = '0;
        else if (load_grant)  mem_addr_d = load_idx;
        else if (fetch_grant) mem_addr_d = fetch_idx;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_addr_q    <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            mem_addr_q    <= mem_addr_d;
            fetch_valid_q <= fetch_grant;
        end
    end

    assign bus.MemAddr    = mem_addr_d;
    assign bus.MemWrEn    = load_grant;
    assign bus.MemWrData  = load_grant ? bus.LoadData : NOP;
    assign bus.LoadAck    = load_grant;
    assign bus.FetchStall = bus.FetchReq && !fetch_grant;
    assign bus.FetchValid = fetch_valid_q && !Rst;

`ifdef IMEM_ALIGN_CHECK_EN
    logic misalign_q, align_err_q;
    logic unused_addr_bits;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            misalign_q  <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            misalign_q  <= fetch_grant && (bus.FetchAddr[1:0] != 2'b00);
            align_err_q <= align_err_q || (fetch_grant && (bus.FetchAddr[1:0] != 2'b00));
        end
    end

    assign bus.FetchInstr = (bus.FetchValid && !misalign_q) ? bus.MemRdData : NOP;
    assign bus.AlignErr   = align_err_q && !Rst;
    assign unused_addr_bits = ^{bus.FetchAddr[31:AW+2], bus.LoadAddr[31:AW+2], bus.LoadAddr[1:0]};
`else
    logic unused_addr_bits;

    assign bus.FetchInstr = bus.FetchValid ? bus.MemRdData : NOP;
    assign bus.AlignErr   = 1'b0;
    assign unused_addr_bits = ^{bus.FetchAddr[31:AW+2], bus.FetchAddr[1:0],
                                bus.LoadAddr[31:AW+2], bus.LoadAddr[1:0]};
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: synchronous-read memory, per-cycle reference model and directed scenarios.
// Expected AlignErr behaviour follows IMEM_ALIGN_CHECK_EN.
module tb_imem_access_arbiter;
    import imem_access_arbiter_pkg::*;

    localparam int DEPTH        = 512;
    localparam int STARVE_LIMIT = 4;
`ifdef IMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    imem_access_arbiter_if #(.DEPTH(DEPTH)) bus ();

    imem_access_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA5000000 | 32'(i);
    endfunction

    function automatic int word_idx(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Environment memory: synchronous read, one-cycle latency.
    logic [31:0] env_mem [DEPTH];
    logic        env_init = 1'b0;
    always @(posedge clk) begin
        logic [31:0] rd;
        if (!env_init) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
            env_init = 1'b1;
        end
        rd = env_mem[bus.MemAddr];
        if (bus.MemWrEn) env_mem[bus.MemAddr] = bus.MemWrData;
        bus.MemRdData <= rd;
    end

    // Reference model state.
    logic [31:0] model_mem [DEPTH];
    bit          m_run      = 1'b0;
    int          m_starve   = 0;
    bit          m_pend     = 1'b0;
    bit          m_pend_mis = 1'b0;
    logic [31:0] m_pend_data = '0;
    bit          m_err      = 1'b0;
    int          m_last     = 0;

    initial for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);

    always @(negedge clk) begin
        bit          lg, fg, mis;
        int          li, fi, e_addr;
        logic [31:0] e_instr;
        bit          e_fv, e_err;
        cyc++;
        li  = word_idx(bus.LoadAddr);
        fi  = word_idx(bus.FetchAddr);
        mis = ALIGN_EN && (bus.FetchAddr[1:0] != 2'b00);
        lg = 1'b0; fg = 1'b0; e_addr = 0; e_fv = 1'b0; e_instr = '0; e_err = 1'b0;
        if (!rst) begin
            if (!m_run) begin
                lg = bus.LoadReq;
            end else if (bus.FetchReq && m_starve == STARVE_LIMIT) begin
                fg = 1'b1;
            end else begin
                lg = bus.LoadReq;
                fg = bus.FetchReq && !bus.LoadReq;
            end
            e_addr  = lg ? li : (fg ? fi : m_last);
            e_fv    = m_pend;
            e_instr = (m_pend && !m_pend_mis) ? m_pend_data : 32'h0;
            e_err   = m_err;
        end
        check($sformatf("c%0d LoadAck", cyc), 32'(bus.LoadAck), 32'(lg));
        check($sformatf("c%0d MemWrEn", cyc), 32'(bus.MemWrEn), 32'(lg));
        check($sformatf("c%0d MemAddr", cyc), 32'(bus.MemAddr), 32'(e_addr));
        check($sformatf("c%0d FetchStall", cyc), 32'(bus.FetchStall), 32'(bus.FetchReq && !fg));
        check($sformatf("c%0d FetchValid", cyc), 32'(bus.FetchValid), 32'(e_fv));
        check($sformatf("c%0d FetchInstr", cyc), bus.FetchInstr, e_instr);
        check($sformatf("c%0d AlignErr", cyc), 32'(bus.AlignErr), 32'(e_err));
        if (lg) check($sformatf("c%0d MemWrData", cyc), bus.MemWrData, bus.LoadData);

        if (rst) begin
            m_run = 1'b0; m_starve = 0; m_pend = 1'b0; m_pend_mis = 1'b0; m_err = 1'b0; m_last = 0;
        end else begin
            m_pend      = fg;
            m_pend_data = model_mem[fi];
            m_pend_mis  = fg && mis;
            if (fg && mis) m_err = 1'b1;
            if (lg) model_mem[li] = bus.LoadData;
            m_last = e_addr;
            if (m_run) begin
                if (fg || !bus.FetchReq)                m_starve = 0;
                else if (lg && m_starve < STARVE_LIMIT) m_starve++;
            end
            if (!m_run && bus.BootDone) m_run = 1'b1;
        end
    end

    initial begin
        logic [5:0] load_pat;
        load_pat = 6'b101111;
        bus.BootDone = 1'b0;
        bus.FetchReq = 1'b1; bus.FetchAddr = 32'h0;
        bus.LoadReq  = 1'b1; bus.LoadAddr  = 32'h20; bus.LoadData = 32'hBAD0BAD0;

        // Reset with both requesters active.
        settle();
        check("rst LoadAck", 32'(bus.LoadAck), 32'h0);
        check("rst MemWrEn", 32'(bus.MemWrEn), 32'h0);
        check("rst MemAddr", 32'(bus.MemAddr), 32'h0);
        check("rst FetchStall", 32'(bus.FetchStall), 32'h1);
        check("rst FetchValid", 32'(bus.FetchValid), 32'h0);
        tick(); tick();
        rst = 1'b0;

        // BOOT: loader wins, fetch stalled.
        bus.LoadAddr = 32'h8; bus.LoadData = 32'hDEADBEEF; bus.FetchAddr = 32'h8;
        settle();
        check("boot LoadAck", 32'(bus.LoadAck), 32'h1);
        check("boot MemWrEn", 32'(bus.MemWrEn), 32'h1);
        check("boot MemAddr", 32'(bus.MemAddr), 32'h2);
        check("boot FetchStall", 32'(bus.FetchStall), 32'h1);
        tick();
        bus.BootDone = 1'b1; bus.LoadReq = 1'b0; bus.FetchReq = 1'b0;
        tick();
        bus.BootDone = 1'b0; bus.FetchReq = 1'b1; bus.FetchAddr = 32'h8;
        settle();
        check("run fetch MemAddr", 32'(bus.MemAddr), 32'h2);
        check("run fetch FetchStall", 32'(bus.FetchStall), 32'h0);
        tick();
        bus.FetchAddr = 32'h808;
        settle();
        check("fetch8 FetchValid", 32'(bus.FetchValid), 32'h1);
        check("fetch8 FetchInstr", bus.FetchInstr, 32'hDEADBEEF);
        check("wrap MemAddr", 32'(bus.MemAddr), 32'h2);
        tick();
        bus.FetchReq = 1'b0;
        settle();
        check("wrap FetchInstr", bus.FetchInstr, 32'hDEADBEEF);
        check("idle MemAddr hold", 32'(bus.MemAddr), 32'h2);
        tick();

        // Write then fetch the same word on the next cycle.
        bus.LoadReq = 1'b1; bus.LoadAddr = 32'h14; bus.LoadData = 32'h12345678;
        settle();
        check("wr5 MemAddr", 32'(bus.MemAddr), 32'h5);
        tick();
        bus.LoadReq = 1'b0; bus.FetchReq = 1'b1; bus.FetchAddr = 32'h14;
        tick();
        bus.FetchAddr = 32'h20;
        settle();
        check("raw FetchInstr", bus.FetchInstr, 32'h12345678);
        tick();
        bus.FetchReq = 1'b0;
        settle();
        check("rst-cycle load dropped", bus.FetchInstr, 32'hA5000008);
        tick();
        tick();

        // Contention: loader four times, then one forced fetch, then loader.
        bus.LoadReq = 1'b1; bus.FetchReq = 1'b1; bus.FetchAddr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            bus.LoadAddr = 32'h100 + 32'(i * 4);
            bus.LoadData = 32'hC0DE0000 + 32'(i);
            settle();
            check($sformatf("starve%0d LoadAck", i + 1), 32'(bus.LoadAck), 32'(load_pat[i]));
            check($sformatf("starve%0d FetchStall", i + 1), 32'(bus.FetchStall), 32'(load_pat[i]));
            tick();
        end

        // Mixed directed traffic checked by the model.
        for (int i = 0; i < 24; i++) begin
            bus.LoadReq   = (i % 3) != 2;
            bus.FetchReq  = (i % 5) != 0;
            bus.LoadAddr  = 32'h40 + 32'(i * 4);
            bus.LoadData  = 32'h5A5A0000 ^ 32'(i);
            bus.FetchAddr = 32'h40 + 32'((i % 7) * 4);
            tick();
        end
        bus.LoadReq = 1'b0; bus.FetchReq = 1'b0;
        tick();

        // Misaligned fetch.
        bus.FetchReq = 1'b1; bus.FetchAddr = 32'h6;
        tick();
        bus.FetchAddr = 32'h8;
        settle();
        check("misalign AlignErr", 32'(bus.AlignErr), 32'(ALIGN_EN));
        check("misalign FetchInstr", bus.FetchInstr, ALIGN_EN ? 32'h0 : 32'hA5000001);
        tick();
        bus.FetchReq = 1'b0;
        settle();
        check("sticky AlignErr", 32'(bus.AlignErr), 32'(ALIGN_EN));
        check("post-misalign FetchInstr", bus.FetchInstr, 32'hDEADBEEF);
        tick();

        // Reset with a fetch in flight.
        bus.FetchReq = 1'b1; bus.FetchAddr = 32'h8;
        tick();
        rst = 1'b1; bus.FetchReq = 1'b0;
        settle();
        check("rst-inflight FetchValid", 32'(bus.FetchValid), 32'h0);
        check("rst-inflight AlignErr", 32'(bus.AlignErr), 32'h0);
        tick();
        rst = 1'b0; bus.FetchReq = 1'b1;
        settle();
        check("post-rst FetchStall", 32'(bus.FetchStall), 32'h1);
        check("post-rst FetchValid", 32'(bus.FetchValid), 32'h0);
        tick();
        bus.FetchReq = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
